mult: RTL

//   Sequential signed multiplier; the counterpart of the divider on the HI/LO path.

---
 rtl/mult.sv | 105 ++++++++++
 1 files changed

// File: rtl/mult.sv
// Sequential signed multiplier for the HI/LO path.
// Radix-2 Booth, one multiplier bit per clock.
module mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             init,
  input  logic             stop,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state;
  logic [WIDTH:0] acc;
  logic [WIDTH-1:0] q;
  logic           q_1;
  logic [WIDTH:0] m;
  logic [CW-1:0]  cnt;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_nx;
  logic [WIDTH-1:0] q_nx;
  logic             q1_nx;
  logic [CW-1:0]    cnt_nx;

  // One Booth step: add/sub by recoded pair, then arithmetic shift.
  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    acc_nx = {sum[WIDTH], sum[WIDTH:1]};
    q_nx   = {sum[0], q[WIDTH-1:1]};
    q1_nx  = q[0];
    cnt_nx = cnt - CW'(1);
  end

  // Control FSM with registered outputs and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      m     <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (stop) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (init) begin
            acc   <= '0;
            q     <= a;
            q_1   <= 1'b0;
            m     <= {b[WIDTH-1], b};
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_nx;
          q   <= q_nx;
          q_1 <= q1_nx;
          cnt <= cnt_nx;
          if (cnt_nx == '0) state <= S_DONE;
        end
        S_DONE: begin
          hi    <= acc[WIDTH-1:0];
          lo    <= q;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
